// File: rtl/stg4mo_mp_pkg.sv
// stg4mo_mp_pkg: shared widths, opcodes, FSM encoding and op-class helpers for memory stage 4
package stg4mo_mp_pkg;
    localparam int DATA_W_DEF   = 24;
    localparam int ADDR_W_DEF   = 24;
    localparam int OPC_W_DEF    = 8;
    localparam int TGT_GP_W_DEF = 4;
    localparam int TGT_SR_W_DEF = 2;

    localparam logic [OPC_W_DEF-1:0] OPC_R_ADD   = 8'h01;
    localparam logic [OPC_W_DEF-1:0] OPC_R_LD    = 8'h10;
    localparam logic [OPC_W_DEF-1:0] OPC_R_ST    = 8'h11;
    localparam logic [OPC_W_DEF-1:0] OPC_I_STi   = 8'h21;
    localparam logic [OPC_W_DEF-1:0] OPC_IS_STis = 8'h31;

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    function automatic logic is_load(input logic [OPC_W_DEF-1:0] opc);
        return opc == OPC_R_LD;
    endfunction

    function automatic logic is_store(input logic [OPC_W_DEF-1:0] opc);
        return opc == OPC_R_ST || opc == OPC_I_STi || opc == OPC_IS_STis;
    endfunction
endpackage

// File: rtl/stg4mo_tmr.sv
// stg4mo_tmr: saturating REQ-cycle counter; expired flags the cycle whose edge reaches TIMEOUT
module stg4mo_tmr #(
    parameter int TIMEOUT = 15
) (
    input  logic iw_clk,
    input  logic iw_rst,
    input  logic iw_clr,
    input  logic iw_en,
    output logic ow_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d      = iw_clr ? '0 : (iw_en && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
        ow_expired = cnt_d == CW'(TIMEOUT);
    end

    always_ff @(posedge iw_clk or posedge iw_rst)
        if (iw_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/stg4mo_mp.sv
// stg4mo_mp: stage-4 memory pipeline stage with per-port req/ack handshake, stall and timeout fault
module stg4mo_mp
    import stg4mo_mp_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int OPC_W     = OPC_W_DEF,
    parameter int TGT_GP_W  = TGT_GP_W_DEF,
    parameter int TGT_SR_W  = TGT_SR_W_DEF,
    parameter int NUM_PORTS = 2,
    parameter int MP_W      = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst,
    input  logic                        iw_valid,
    output logic                        ow_stall,
    input  logic [ADDR_W-1:0]           iw_pc,
    input  logic [DATA_W-1:0]           iw_instr,
    input  logic [OPC_W-1:0]            iw_opc,
    input  logic [TGT_GP_W-1:0]         iw_tgt_gp,
    input  logic                        iw_tgt_gp_we,
    input  logic [TGT_SR_W-1:0]         iw_tgt_sr,
    input  logic                        iw_tgt_sr_we,
    input  logic [DATA_W-1:0]           iw_result,
    input  logic [ADDR_W-1:0]           iw_mem_addr,
    input  logic [MP_W-1:0]             iw_mem_mp,
    output logic [ADDR_W-1:0]           ow_pc,
    output logic [DATA_W-1:0]           ow_instr,
    output logic [OPC_W-1:0]            ow_opc,
    output logic [TGT_GP_W-1:0]         ow_tgt_gp,
    output logic                        ow_tgt_gp_we,
    output logic [TGT_SR_W-1:0]         ow_tgt_sr,
    output logic                        ow_tgt_sr_we,
    output logic [DATA_W-1:0]           ow_result,
    output logic                        ow_valid,
    output logic                        ow_fault,
    output logic [NUM_PORTS-1:0]        ow_mem_req,
    output logic [NUM_PORTS-1:0]        ow_mem_we,
    output logic [NUM_PORTS*ADDR_W-1:0] ow_mem_addr,
    output logic [NUM_PORTS*DATA_W-1:0] ow_mem_wdata,
    input  logic [NUM_PORTS-1:0]        iw_mem_ack,
    input  logic [NUM_PORTS*DATA_W-1:0] iw_mem_rdata
);
    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic [DATA_W-1:0]   instr;
        logic [OPC_W-1:0]    opc;
        logic [TGT_GP_W-1:0] tgt_gp;
        logic                gp_we;
        logic [TGT_SR_W-1:0] tgt_sr;
        logic                sr_we;
        logic [DATA_W-1:0]   result;
    } pay_t;

    state_t            st_q, st_d;
    pay_t              out_q, out_d, hold_q, hold_d, in_p;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MP_W-1:0]   mp_q, mp_d;
    logic              valid_q, valid_d, fault_q, fault_d;
    logic              tmr_clr, tmr_en, tmr_exp, ack_sel;

    stg4mo_tmr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_clr(tmr_clr), .iw_en(tmr_en), .ow_expired(tmr_exp)
    );

    assign in_p    = '{iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_result};
    assign ack_sel = iw_mem_ack[mp_q];

    always_comb begin
        st_d         = st_q;
        out_d        = out_q;
        out_d.gp_we  = 1'b0;
        out_d.sr_we  = 1'b0;
        hold_d       = hold_q;
        addr_d       = addr_q;
        mp_d         = mp_q;
        valid_d      = 1'b0;
        fault_d      = 1'b0;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        if (st_q == ST_IDLE && iw_valid) begin
            if (!(is_load(iw_opc) || is_store(iw_opc))) begin
                out_d   = in_p;
                valid_d = 1'b1;
            end else if (32'(iw_mem_mp) < NUM_PORTS) begin
                hold_d  = in_p;
                addr_d  = iw_mem_addr;
                mp_d    = iw_mem_mp;
                tmr_clr = 1'b1;
                st_d    = ST_REQ;
            end else begin
                out_d        = in_p;
                out_d.result = '0;
                out_d.gp_we  = 1'b0;
                out_d.sr_we  = 1'b0;
                valid_d      = 1'b1;
                fault_d      = 1'b1;
            end
        end else if (st_q == ST_REQ) begin
            tmr_en = 1'b1;
            // Ack beats a timeout landing on the same edge
            if (ack_sel) begin
                out_d        = hold_q;
                out_d.result = is_load(hold_q.opc) ? iw_mem_rdata[32'(mp_q)*DATA_W +: DATA_W] : hold_q.result;
                valid_d      = 1'b1;
                st_d         = ST_IDLE;
            end else if (tmr_exp) begin
                out_d        = hold_q;
                out_d.result = '0;
                out_d.gp_we  = 1'b0;
                out_d.sr_we  = 1'b0;
                valid_d      = 1'b1;
                fault_d      = 1'b1;
                st_d         = ST_IDLE;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst)
        if (iw_rst) begin
            st_q    <= ST_IDLE;
            out_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            mp_q    <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            out_q   <= out_d;
            hold_q  <= hold_d;
            addr_q  <= addr_d;
            mp_q    <= mp_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end

    // Port drive derives only from registered state, so async reset drops it at once
    always_comb begin
        ow_mem_req   = '0;
        ow_mem_we    = '0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            if (st_q == ST_REQ && 32'(mp_q) == k) begin
                ow_mem_req[k]                   = 1'b1;
                ow_mem_we[k]                    = is_store(hold_q.opc);
                ow_mem_addr[k*ADDR_W +: ADDR_W] = addr_q;
                ow_mem_wdata[k*DATA_W +: DATA_W] = is_store(hold_q.opc) ? hold_q.result : '0;
            end
    end

    assign ow_stall     = st_q == ST_REQ;
    assign ow_pc        = out_q.pc;
    assign ow_instr     = out_q.instr;
    assign ow_opc       = out_q.opc;
    assign ow_tgt_gp    = out_q.tgt_gp;
    assign ow_tgt_gp_we = out_q.gp_we;
    assign ow_tgt_sr    = out_q.tgt_sr;
    assign ow_tgt_sr_we = out_q.sr_we;
    assign ow_result    = out_q.result;
    assign ow_valid     = valid_q;
    assign ow_fault     = fault_q;
endmodule

// File: tb/tb_stg4mo_mp.sv
// tb_stg4mo_mp: directed vector table plus hand sequences for handshake, timeout, bad port and reset
module tb_stg4mo_mp;
    import stg4mo_mp_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0;
    logic [23:0] pc = '0, instr = '0, result = '0, maddr = '0;
    logic [7:0]  opc = '0;
    logic [3:0]  tgt_gp = '0;
    logic [1:0]  tgt_sr = '0, mp = '0;
    logic        gp_we = 1'b0, sr_we = 1'b0;
    logic [2:0]  ack = '0;
    logic [71:0] rdata = '0;

    logic        o2_stall, o2_gp_we, o2_sr_we, o2_valid, o2_fault;
    logic [23:0] o2_pc, o2_instr, o2_result;
    logic [7:0]  o2_opc;
    logic [3:0]  o2_tgt_gp;
    logic [1:0]  o2_tgt_sr, o2_req, o2_we;
    logic [47:0] o2_addr, o2_wdata;

    logic        o3_stall, o3_gp_we, o3_sr_we, o3_valid, o3_fault;
    logic [23:0] o3_pc, o3_instr, o3_result;
    logic [7:0]  o3_opc;
    logic [3:0]  o3_tgt_gp;
    logic [1:0]  o3_tgt_sr;
    logic [2:0]  o3_req, o3_we;
    logic [71:0] o3_addr, o3_wdata;

    int n_tests = 0, n_fail = 0;

    stg4mo_mp u2 (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(valid), .ow_stall(o2_stall),
        .iw_pc(pc), .iw_instr(instr), .iw_opc(opc), .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we), .iw_result(result), .iw_mem_addr(maddr), .iw_mem_mp(mp[0]),
        .ow_pc(o2_pc), .ow_instr(o2_instr), .ow_opc(o2_opc), .ow_tgt_gp(o2_tgt_gp), .ow_tgt_gp_we(o2_gp_we),
        .ow_tgt_sr(o2_tgt_sr), .ow_tgt_sr_we(o2_sr_we), .ow_result(o2_result), .ow_valid(o2_valid), .ow_fault(o2_fault),
        .ow_mem_req(o2_req), .ow_mem_we(o2_we), .ow_mem_addr(o2_addr), .ow_mem_wdata(o2_wdata),
        .iw_mem_ack(ack[1:0]), .iw_mem_rdata(rdata[47:0])
    );

    stg4mo_mp #(.NUM_PORTS(3), .MP_W(2)) u3 (
        .iw_clk(clk), .iw_rst(rst), .iw_valid(valid), .ow_stall(o3_stall),
        .iw_pc(pc), .iw_instr(instr), .iw_opc(opc), .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we),
        .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we), .iw_result(result), .iw_mem_addr(maddr), .iw_mem_mp(mp),
        .ow_pc(o3_pc), .ow_instr(o3_instr), .ow_opc(o3_opc), .ow_tgt_gp(o3_tgt_gp), .ow_tgt_gp_we(o3_gp_we),
        .ow_tgt_sr(o3_tgt_sr), .ow_tgt_sr_we(o3_sr_we), .ow_result(o3_result), .ow_valid(o3_valid), .ow_fault(o3_fault),
        .ow_mem_req(o3_req), .ow_mem_we(o3_we), .ow_mem_addr(o3_addr), .ow_mem_wdata(o3_wdata),
        .iw_mem_ack(ack), .iw_mem_rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [7:0] o, input logic [1:0] p, input logic [23:0] a,
                         input logic [23:0] r, input logic g);
        valid = 1'b1; opc = o; mp = p; maddr = a; result = r; gp_we = g; sr_we = 1'b0;
    endtask

    typedef struct {
        logic v; logic [7:0] o; logic [23:0] r; logic gw, sw;
        logic ev; logic [23:0] er; logic egw, esw;
    } vec_t;
    vec_t tbl[5];

    initial begin
        int n;
        tbl[0] = '{1'b1, OPC_R_ADD, 24'h00ABCD, 1'b1, 1'b0, 1'b1, 24'h00ABCD, 1'b1, 1'b0};
        tbl[1] = '{1'b0, OPC_R_ADD, 24'h111111, 1'b1, 1'b1, 1'b0, 24'h00ABCD, 1'b0, 1'b0};
        tbl[2] = '{1'b1, OPC_R_ADD, 24'h000001, 1'b0, 1'b1, 1'b1, 24'h000001, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 8'h55,     24'hFFFFFF, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1};
        tbl[4] = '{1'b0, OPC_R_LD,  24'h222222, 1'b1, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0};

        tick();
        chk("rst_valid", o2_valid, 0);
        chk("rst_fault", o2_fault, 0);
        chk("rst_result", o2_result, 0);
        chk("rst_pc", o2_pc, 0);
        chk("rst_req", o2_req, 0);
        chk("rst_we", o2_we, 0);
        chk("rst_addr", 32'(|o2_addr), 0);
        chk("rst_wdata", 32'(|o2_wdata), 0);
        chk("rst_stall", o2_stall, 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            valid = tbl[i].v; opc = tbl[i].o; result = tbl[i].r; gp_we = tbl[i].gw; sr_we = tbl[i].sw;
            tick();
            chk($sformatf("vec%0d_valid", i), o2_valid, tbl[i].ev);
            chk($sformatf("vec%0d_result", i), o2_result, tbl[i].er);
            chk($sformatf("vec%0d_gpwe", i), o2_gp_we, tbl[i].egw);
            chk($sformatf("vec%0d_srwe", i), o2_sr_we, tbl[i].esw);
            chk($sformatf("vec%0d_fault", i), o2_fault, 0);
            chk($sformatf("vec%0d_req", i), o2_req, 0);
            chk($sformatf("vec%0d_stall", i), o2_stall, 0);
        end

        issue(OPC_R_LD, 2'd1, 24'h000100, 24'h999999, 1'b1);
        tick();
        valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ld_req", o2_req, 2'b10);
            chk("ld_stall", o2_stall, 1);
            chk("ld_addr", o2_addr[47:24], 24'h000100);
            chk("ld_addr0", o2_addr[23:0], 0);
            chk("ld_bubble", o2_valid, 0);
            if (c == 2) begin ack = 3'b010; rdata = {24'h0, 24'h123456, 24'hAAAAAA}; end
            tick();
        end
        ack = '0;
        chk("ld_valid", o2_valid, 1);
        chk("ld_result", o2_result, 24'h123456);
        chk("ld_gpwe", o2_gp_we, 1);
        chk("ld_fault", o2_fault, 0);
        chk("ld_req_drop", o2_req, 0);
        chk("ld_stall_drop", o2_stall, 0);

        issue(OPC_I_STi, 2'd0, 24'h000040, 24'h00FF00, 1'b0);
        ack = 3'b001;
        tick();
        valid = 1'b0;
        chk("st_req", o2_req, 2'b01);
        chk("st_we", o2_we, 2'b01);
        chk("st_wdata", o2_wdata[23:0], 24'h00FF00);
        chk("st_bubble", o2_valid, 0);
        tick();
        ack = '0;
        chk("st_valid", o2_valid, 1);
        chk("st_result", o2_result, 24'h00FF00);
        chk("st_fault", o2_fault, 0);
        chk("st_we_drop", o2_we, 0);

        issue(OPC_R_LD, 2'd0, 24'h000200, 24'h111111, 1'b1);
        tick();
        valid = 1'b0;
        n = 0;
        while (o2_req[0] && n < 40) begin
            n++;
            tick();
        end
        chk("to_len", n, 15);
        chk("to_fault", o2_fault, 1);
        chk("to_result", o2_result, 0);
        chk("to_gpwe", o2_gp_we, 0);
        chk("to_valid", o2_valid, 1);
        chk("to_stall", o2_stall, 0);

        issue(OPC_R_LD, 2'd0, 24'h000300, 24'h111111, 1'b1);
        tick();
        valid = 1'b0;
        repeat (14) tick();
        chk("race_stall", o2_stall, 1);
        ack = 3'b001;
        rdata = {48'h0, 24'h5A5A5A};
        tick();
        ack = '0;
        chk("race_fault", o2_fault, 0);
        chk("race_result", o2_result, 24'h5A5A5A);
        chk("race_valid", o2_valid, 1);

        do_reset();
        issue(OPC_R_LD, 2'd3, 24'h000400, 24'h333333, 1'b1);
        tick();
        valid = 1'b0;
        chk("bad_fault", o3_fault, 1);
        chk("bad_valid", o3_valid, 1);
        chk("bad_result", o3_result, 0);
        chk("bad_gpwe", o3_gp_we, 0);
        chk("bad_req", o3_req, 0);
        chk("bad_stall", o3_stall, 0);

        do_reset();
        ack = 3'b100;
        issue(OPC_R_LD, 2'd0, 24'h000500, 24'h0, 1'b1);
        tick();
        valid = 1'b0;
        repeat (3) begin
            chk("stray_req", o3_req, 3'b001);
            chk("stray_bubble", o3_valid, 0);
            tick();
        end
        ack = 3'b001;
        rdata = {48'h0, 24'h0A0B0C};
        tick();
        ack = '0;
        chk("stray_valid", o3_valid, 1);
        chk("stray_result", o3_result, 24'h0A0B0C);
        chk("stray_fault", o3_fault, 0);

        do_reset();
        issue(OPC_R_LD, 2'd1, 24'h000600, 24'h444444, 1'b1);
        tick();
        valid = 1'b0;
        tick();
        chk("mid_req_pre", o2_req, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("mid_req", o2_req, 0);
        chk("mid_addr", 32'(|o2_addr), 0);
        chk("mid_stall", o2_stall, 0);
        chk("mid_valid", o2_valid, 0);
        chk("mid_result", o2_result, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(OPC_R_ADD, 2'd0, 24'h0, 24'h000777, 1'b1);
        tick();
        valid = 1'b0;
        chk("post_valid", o2_valid, 1);
        chk("post_result", o2_result, 24'h000777);
        chk("post_req", o2_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
